// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: micro-op payload, queue entry and ALU opcodes.
package alu_issue_queue_pkg;

    localparam int unsigned NUM_PHYSICAL_REGS = 64;
    localparam int unsigned TAG_W             = $clog2(NUM_PHYSICAL_REGS);
    localparam int unsigned OPC_W             = 6;
    localparam int unsigned IMM_W             = 16;

    localparam logic [OPC_W-1:0] UOP_ALU_ADD = 6'h01;
    localparam logic [OPC_W-1:0] UOP_ALU_SUB = 6'h02;
    localparam logic [OPC_W-1:0] UOP_ALU_AND = 6'h03;
    localparam logic [OPC_W-1:0] UOP_ALU_OR  = 6'h04;
    localparam logic [OPC_W-1:0] UOP_ALU_XOR = 6'h05;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [TAG_W-1:0] dst;
        logic [TAG_W-1:0] operand_a;
        logic [TAG_W-1:0] operand_b;
        logic [IMM_W-1:0] imm;
    } micro_op_t;

    typedef struct packed {
        logic      valid;
        logic      rdy_a;
        logic      rdy_b;
        micro_op_t uop;
    } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch-to-issue-queue handshake: uop, dispatch-time operand readiness and back-pressure.
interface alu_issue_queue_if;
    import alu_issue_queue_pkg::*;

    logic      uop_p;
    micro_op_t uop;
    logic      rdy_a;
    logic      rdy_b;
    logic      stall;

    modport master (output uop_p, output uop, output rdy_a, output rdy_b, input stall);
    modport slave  (input uop_p, input uop, input rdy_a, input rdy_b, output stall);

endinterface

// File: rtl/alu_iq_select.sv
// Find-first-set over ready bits: lowest index (oldest entry) wins.
module alu_iq_select #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         i_ready,
    output logic [N-1:0]         o_grant_c,
    output logic [$clog2(N)-1:0] o_grant_idx_c,
    output logic                 o_any_ready_c
);
    localparam int unsigned IDX_W = $clog2(N);

    // Scan high to low so the last hit is the lowest ready index.
    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        o_any_ready_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_grant_c     = '0;
                o_grant_c[i]  = 1'b1;
                o_grant_idx_c = IDX_W'(i);
                o_any_ready_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing ALU reservation station: wakeup, oldest-ready select, registered issue.
// Optional perf counters under ALU_ISSUE_QUEUE_PERF_EN.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned IQ_DEPTH     = 8,
    parameter int unsigned NUM_WB_PORTS = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    alu_issue_queue_if.slave                      disp,
    input  logic [NUM_WB_PORTS-1:0]               i_wb_we,
    input  logic [NUM_WB_PORTS-1:0][TAG_W-1:0]    i_wb_trgt,
    input  logic                                  i_flush,
    output logic                                  o_uop_p,
    output micro_op_t                             o_uop,
    input  logic                                  i_alu_stall,
    output logic [$clog2(IQ_DEPTH+1)-1:0]         o_count
`ifdef ALU_ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]                           o_perf_issued,
    output logic [31:0]                           o_perf_full_cyc
`endif
);
    localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(IQ_DEPTH);

    iq_entry_t [IQ_DEPTH-1:0] entries_q, entries_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     stall_q, stall_d;
    logic                     uop_p_q, uop_p_d;
    micro_op_t                uop_q, uop_d;

    iq_entry_t [IQ_DEPTH-1:0] woken_c;
    iq_entry_t                disp_entry_c;
    logic [IQ_DEPTH-1:0]      ready_c;
    logic [IQ_DEPTH-1:0]      grant_c;
    logic [IDX_W-1:0]         grant_idx_c;
    logic                     any_ready_c;
    micro_op_t                sel_uop_c;
    logic                     issue_c;
    logic                     disp_c;
    logic [IDX_W-1:0]         disp_idx_c;

    // Readiness is judged on pre-edge state; wakeups only land in next state.
    always_comb begin
        for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            woken_c[i] = entries_q[i];
            ready_c[i] = entries_q[i].valid & entries_q[i].rdy_a & entries_q[i].rdy_b;
            if (entries_q[i].valid) begin
                for (int k = 0; k < int'(NUM_WB_PORTS); k++) begin
                    if (i_wb_we[k] && (i_wb_trgt[k] == entries_q[i].uop.operand_a))
                        woken_c[i].rdy_a = 1'b1;
                    if (i_wb_we[k] && (i_wb_trgt[k] == entries_q[i].uop.operand_b))
                        woken_c[i].rdy_b = 1'b1;
                end
            end
        end
    end

    // Incoming entry also snoops this cycle's writebacks.
    always_comb begin
        disp_entry_c       = '0;
        disp_entry_c.valid = 1'b1;
        disp_entry_c.uop   = disp.uop;
        disp_entry_c.rdy_a = disp.rdy_a;
        disp_entry_c.rdy_b = disp.rdy_b;
        for (int k = 0; k < int'(NUM_WB_PORTS); k++) begin
            if (i_wb_we[k] && (i_wb_trgt[k] == disp.uop.operand_a)) disp_entry_c.rdy_a = 1'b1;
            if (i_wb_we[k] && (i_wb_trgt[k] == disp.uop.operand_b)) disp_entry_c.rdy_b = 1'b1;
        end
    end

    alu_iq_select #(
        .N (IQ_DEPTH)
    ) u_select (
        .i_ready       (ready_c),
        .o_grant_c     (grant_c),
        .o_grant_idx_c (grant_idx_c),
        .o_any_ready_c (any_ready_c)
    );

    always_comb begin
        sel_uop_c = '0;
        for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            if (grant_c[i]) sel_uop_c = entries_q[i].uop;
        end
    end

    // Issue, compaction, dispatch and flush.
    always_comb begin
        issue_c    = any_ready_c & ~i_alu_stall;
        disp_c     = disp.uop_p & ~stall_q;
        entries_d  = woken_c;
        uop_p_d    = uop_p_q;
        uop_d      = uop_q;
        disp_idx_c = IDX_W'(count_q - CNT_W'(issue_c));
        count_d    = count_q + CNT_W'(disp_c) - CNT_W'(issue_c);

        if (!i_alu_stall) begin
            uop_p_d = any_ready_c;
            uop_d   = any_ready_c ? sel_uop_c : '0;
        end

        if (issue_c) begin
            for (int i = 0; i < int'(IQ_DEPTH) - 1; i++) begin
                if (i >= int'(grant_idx_c)) entries_d[i] = woken_c[i+1];
            end
            entries_d[IQ_DEPTH-1] = '0;
        end

        // Survivors have already been compacted, so the tail slot is free.
        if (disp_c) entries_d[disp_idx_c] = disp_entry_c;

        if (i_flush) begin
            entries_d = '0;
            uop_p_d   = 1'b0;
            uop_d     = '0;
            count_d   = '0;
        end

        stall_d = (count_d == CNT_W'(IQ_DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            entries_q <= '0;
            count_q   <= '0;
            stall_q   <= 1'b0;
            uop_p_q   <= 1'b0;
            uop_q     <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
            uop_p_q   <= uop_p_d;
            uop_q     <= uop_d;
        end
    end

    assign o_uop_p    = uop_p_q;
    assign o_uop      = uop_q;
    assign o_count    = count_q;
    assign disp.stall = stall_q;

`ifdef ALU_ISSUE_QUEUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_full_cyc_q, perf_full_cyc_d;

    // Survive flush; only reset clears them.
    always_comb begin
        perf_issued_d   = perf_issued_q + 32'(issue_c & ~i_flush);
        perf_full_cyc_d = perf_full_cyc_q + 32'(stall_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            perf_issued_q   <= '0;
            perf_full_cyc_q <= '0;
        end else begin
            perf_issued_q   <= perf_issued_d;
            perf_full_cyc_q <= perf_full_cyc_d;
        end
    end

    assign o_perf_issued   = perf_issued_q;
    assign o_perf_full_cyc = perf_full_cyc_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed scoreboard bench for alu_issue_queue: expected issue order queued, monitor compares.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [3:0]            wb_we;
    logic [3:0][TAG_W-1:0] wb_trgt;
    logic                  flush;
    logic                  alu_stall;
    logic                  o_uop_p;
    micro_op_t             o_uop;
    logic [3:0]            o_count;
`ifdef ALU_ISSUE_QUEUE_PERF_EN
    logic [31:0]           perf_issued;
    logic [31:0]           perf_full_cyc;
`endif

    alu_issue_queue_if disp_if ();

    alu_issue_queue #(
        .IQ_DEPTH     (8),
        .NUM_WB_PORTS (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .disp         (disp_if),
        .i_wb_we      (wb_we),
        .i_wb_trgt    (wb_trgt),
        .i_flush      (flush),
        .o_uop_p      (o_uop_p),
        .o_uop        (o_uop),
        .i_alu_stall  (alu_stall),
        .o_count      (o_count)
`ifdef ALU_ISSUE_QUEUE_PERF_EN
        ,
        .o_perf_issued   (perf_issued),
        .o_perf_full_cyc (perf_full_cyc)
`endif
    );

    int        checks = 0;
    int        errors = 0;
    micro_op_t exp_q[$];
    logic      stall_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic micro_op_t mk(input logic [5:0] op, input int dst, input int a, input int b,
                                     input int imm);
        micro_op_t u;
        u.opcode    = op;
        u.dst       = TAG_W'(dst);
        u.operand_a = TAG_W'(a);
        u.operand_b = TAG_W'(b);
        u.imm       = IMM_W'(imm);
        return u;
    endfunction

    // ALU consumes the issue register only on edges where it was not stalling.
    always @(posedge clk) stall_seen <= alu_stall;

    always @(negedge clk) begin
        if (o_uop_p === 1'b1 && !stall_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got %0h expected none", o_uop);
            end else begin
                micro_op_t e;
                e = exp_q.pop_front();
                check("issue_order", 64'(o_uop), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input micro_op_t u, input logic ra, input logic rb);
        disp_if.uop_p = 1'b1;
        disp_if.uop   = u;
        disp_if.rdy_a = ra;
        disp_if.rdy_b = rb;
    endtask

    task automatic idle();
        disp_if.uop_p = 1'b0;
        disp_if.rdy_a = 1'b0;
        disp_if.rdy_b = 1'b0;
    endtask

    micro_op_t u, u0, u1, u2, x, s1, s2, r1, r2;

    initial begin
        rst = 1'b0; flush = 1'b0; alu_stall = 1'b0; wb_we = '0; wb_trgt = '0;
        disp_if.uop = '0;
        idle();
        tick(); tick();
        check("rst_uop_p", 64'(o_uop_p), 0);
        check("rst_uop",   64'(o_uop), 0);
        check("rst_count", 64'(o_count), 0);
        check("rst_stall", 64'(disp_if.stall), 0);
        rst = 1'b1;
        tick();

        // Basic issue
        u = mk(UOP_ALU_ADD, 1, 3, 4, 16'h1234);
        exp_q.push_back(u);
        drive(u, 1'b1, 1'b1);
        tick();
        idle();
        check("t1_count1", 64'(o_count), 1);
        tick();
        check("t1_issue", 64'(o_uop_p), 1);
        check("t1_uop",   64'(o_uop), 64'(u));
        check("t1_count0", 64'(o_count), 0);
        tick();
        check("t1_idle", 64'(o_uop_p), 0);

        // Wakeup on port 2, issue one cycle after the wakeup edge
        u = mk(UOP_ALU_SUB, 2, 5, 9, 16'h0002);
        drive(u, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("t2_wait", 64'(o_uop_p), 0);
        wb_we[2] = 1'b1; wb_trgt[2] = TAG_W'(9);
        tick();
        check("t2_no_early", 64'(o_uop_p), 0);
        wb_we = '0;
        exp_q.push_back(u);
        tick();
        check("t2_issue", 64'(o_uop_p), 1);
        check("t2_uop",   64'(o_uop), 64'(u));
        check("t2_count0", 64'(o_count), 0);

        // Wakeup coinciding with dispatch
        u = mk(UOP_ALU_XOR, 3, 12, 13, 16'h0003);
        drive(u, 1'b0, 1'b1);
        wb_we[1] = 1'b1; wb_trgt[1] = TAG_W'(12);
        exp_q.push_back(u);
        tick();
        idle();
        wb_we = '0;
        check("t2b_count1", 64'(o_count), 1);
        tick();
        check("t2b_issue", 64'(o_uop), 64'(u));

        // Ordering and compaction
        u0 = mk(UOP_ALU_AND, 4, 10, 11, 16'h0010);
        u1 = mk(UOP_ALU_OR,  5, 1, 2, 16'h0011);
        u2 = mk(UOP_ALU_ADD, 6, 7, 8, 16'h0012);
        exp_q.push_back(u1);
        exp_q.push_back(u2);
        drive(u0, 1'b1, 1'b0);
        tick();
        drive(u1, 1'b1, 1'b1);
        tick();
        check("t3_count2", 64'(o_count), 2);
        drive(u2, 1'b1, 1'b1);
        tick();
        idle();
        check("t3_u1", 64'(o_uop), 64'(u1));
        check("t3_count_keep", 64'(o_count), 2);
        tick();
        check("t3_u2", 64'(o_uop), 64'(u2));
        check("t3_count1", 64'(o_count), 1);
        wb_we[0] = 1'b1; wb_trgt[0] = TAG_W'(11);
        tick();
        wb_we = '0;
        check("t3_u0_wait", 64'(o_uop_p), 0);
        exp_q.push_back(u0);
        tick();
        check("t3_u0", 64'(o_uop), 64'(u0));
        check("t3_count0", 64'(o_count), 0);

        // Full queue
        for (int i = 0; i < 8; i++) begin
            drive(mk(UOP_ALU_SUB, 16 + i, 30, 20 + i, i), 1'b1, 1'b0);
            tick();
        end
        check("t4_count8", 64'(o_count), 8);
        check("t4_stall1", 64'(disp_if.stall), 1);
        x = mk(UOP_ALU_XOR, 63, 1, 1, 16'h0055);
        drive(x, 1'b1, 1'b1);
        tick();
        idle();
        check("t4_refused", 64'(o_count), 8);
        wb_we[3] = 1'b1; wb_trgt[3] = TAG_W'(23);
        tick();
        wb_we = '0;
        check("t4_stall_wake", 64'(disp_if.stall), 1);
        exp_q.push_back(mk(UOP_ALU_SUB, 19, 30, 23, 3));
        drive(x, 1'b1, 1'b1);
        tick();
        idle();
        check("t4_issue", 64'(o_uop_p), 1);
        check("t4_no_refill", 64'(o_count), 7);
        check("t4_stall_drop", 64'(disp_if.stall), 0);
        flush = 1'b1;
        drive(x, 1'b1, 1'b1);
        tick();
        flush = 1'b0;
        idle();
        check("t4_flush_count", 64'(o_count), 0);
        check("t4_flush_uop_p", 64'(o_uop_p), 0);
        tick();
        check("t4_flush_drop", 64'(o_uop_p), 0);

        // ALU stall holds the issue register
        s1 = mk(UOP_ALU_ADD, 7, 1, 2, 16'h0011);
        s2 = mk(UOP_ALU_SUB, 8, 3, 4, 16'h0022);
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        drive(s1, 1'b1, 1'b1);
        tick();
        drive(s2, 1'b1, 1'b1);
        tick();
        idle();
        alu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_p",   64'(o_uop_p), 1);
            check("t5_hold_uop", 64'(o_uop), 64'(s1));
            check("t5_hold_cnt", 64'(o_count), 1);
        end
        alu_stall = 1'b0;
        tick();
        check("t5_s2", 64'(o_uop), 64'(s2));
        check("t5_count0", 64'(o_count), 0);
        tick();
        check("t5_idle", 64'(o_uop_p), 0);

        // Flush with five entries, then wake their tags
        for (int i = 0; i < 5; i++) begin
            drive(mk(UOP_ALU_AND, i, 31, 40 + i, 0), 1'b1, 1'b0);
            tick();
        end
        check("t6_count5", 64'(o_count), 5);
        flush = 1'b1;
        drive(mk(UOP_ALU_OR, 9, 1, 2, 0), 1'b1, 1'b1);
        tick();
        flush = 1'b0;
        idle();
        check("t6_count0", 64'(o_count), 0);
        check("t6_uop_p0", 64'(o_uop_p), 0);
        wb_we = 4'hF;
        wb_trgt[0] = TAG_W'(40); wb_trgt[1] = TAG_W'(41);
        wb_trgt[2] = TAG_W'(42); wb_trgt[3] = TAG_W'(43);
        tick();
        wb_we = '0;
        tick();
        check("t6_no_ghost", 64'(o_uop_p), 0);

        // Reset mid-issue
        r1 = mk(UOP_ALU_ADD, 10, 1, 2, 16'h0033);
        r2 = mk(UOP_ALU_SUB, 11, 3, 4, 16'h0044);
        exp_q.push_back(r1);
        drive(r1, 1'b1, 1'b1);
        tick();
        drive(r2, 1'b1, 1'b1);
        tick();
        idle();
        check("t7_issue", 64'(o_uop_p), 1);
        rst = 1'b0;
        tick();
        check("t7_rst_uop_p", 64'(o_uop_p), 0);
        check("t7_rst_uop",   64'(o_uop), 0);
        check("t7_rst_count", 64'(o_count), 0);
        check("t7_rst_stall", 64'(disp_if.stall), 0);
        rst = 1'b1;
        tick();
        tick();
        check("t7_dropped", 64'(o_uop_p), 0);

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station directly upstream of arithmetic_and_logic_unit.
- Accepts renamed micro-ops from dispatch and tracks source-operand readiness via PRF writeback wakeups.
- Issues the oldest ready uop into the ALU's i_uop_p/i_uop interface, one per cycle, honouring the ALU stall.
- Collapsing queue: index 0 is always the oldest entry.

Parameters:
- NUM_PHYSICAL_REGS, 64, PRF size; tag width = $clog2(NUM_PHYSICAL_REGS).
- IQ_DEPTH, 8, number of queue entries; must be >= 2.
- NUM_WB_PORTS, 4, number of PRF write ports snooped for wakeup.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_uop_p  in  1  dispatch uop present.
- i_uop  in  micro_op_t  dispatched uop; operand_a/operand_b are source physical tags.
- i_rdy_a  in  1  operand_a already valid in PRF at dispatch.
- i_rdy_b  in  1  operand_b already valid in PRF at dispatch.
- o_stall  out  1  queue full; dispatch must hold.
- i_wb_we  in  NUM_WB_PORTS  PRF write enables.
- i_wb_trgt  in  NUM_WB_PORTS x tag  PRF write targets.
- i_flush  in  1  pipeline flush.
- o_uop_p  out  1  issue valid, to ALU i_uop_p.
- o_uop  out  micro_op_t  issued uop, to ALU i_uop.
- i_alu_stall  in  1  ALU o_stall.
- o_count  out  $clog2(IQ_DEPTH+1)  occupancy.

Behaviour:
- Reset (i_rst==0 at posedge): all entry valid bits 0; o_uop_p=0; o_uop=0; o_count=0; o_stall=0. Reset has priority over flush, dispatch and issue. Reset mid-operation drops all held and issued uops.
- Entry state: {valid, rdy_a, rdy_b, uop}. An entry is ready when valid && rdy_a && rdy_b.
- Wakeup, every posedge: for each valid entry and each port k with i_wb_we[k], set rdy_a if operand_a==i_wb_trgt[k]; likewise rdy_b. Applies to entries already held and to the entry being dispatched that cycle (dispatch rdy = i_rdy_x OR wakeup match).
- Select: combinational, over entry state before the edge. Picks the lowest-index ready entry. Wakeups at edge N make an entry eligible at edge N+1 earliest, matching the PRF write-then-read timing.
- Issue register: o_uop_p/o_uop registered.
  - At posedge with i_alu_stall==0: o_uop_p <= any_ready; o_uop <= selected uop; selected entry removed.
  - With i_alu_stall==1: output register holds and no entry is removed.
  - Issue-to-ALU latency: 1 cycle after readiness is visible.
- Removal/compaction: entries above the removed index shift down one; order is preserved.
- Dispatch: when i_uop_p && !o_stall, write the new entry at index (count - removed_this_cycle), i.e. behind all survivors.
- o_stall = (o_count == IQ_DEPTH), driven from registered count. When full, dispatch is refused even if an issue frees a slot that cycle; no same-cycle refill at full.
- Count update: count <= count + dispatched - issued. Simultaneous dispatch and issue leaves count unchanged.
- Empty: o_uop_p <= 0 at next unstalled edge; no spurious issue.
- Flush (i_flush==1, reset inactive): all valid bits 0, o_uop_p<=0, count<=0. Any dispatch that cycle is dropped.
- A uop never issues twice and never issues before both ready bits are set.

Optional Feature:
- Macro: ALU_ISSUE_QUEUE_PERF_EN.
- Defined: adds outputs o_perf_issued [31:0] (count of issues) and o_perf_full_cyc [31:0] (cycles with o_stall==1). Both wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package / structs.svh: micro_op_t (existing), new iq_entry_t {valid, rdy_a, rdy_b, micro_op_t uop}.
- defines.svh: UOP_ALU_* opcodes (existing, unused by selection logic).
- One sub-module: alu_iq_select. Find-first-set over IQ_DEPTH ready bits; outputs one-hot grant, grant index and any_ready.

Test Plan:
- Basic issue: dispatch ADD with tags a=3, b=4, both rdy → o_uop_p=1 with that uop at edge+1; o_count returns to 0.
- Wakeup: dispatch with rdy_b=0 on tag 9; pulse i_wb_we[2], i_wb_trgt[2]=9 two cycles later → issue exactly one cycle after the wakeup edge, never before.
- Ordering: dispatch U0 (not ready) then U1 and U2 (ready) → U1 issues, then U2; wake U0 → U0 issues next; order is preserved after compaction.
- Full: fill 8 non-ready entries → o_stall=1, a 9th dispatch is ignored; wake one entry → it issues and o_stall drops the following cycle.
- ALU stall: assert i_alu_stall for 3 cycles with a ready entry → o_uop held constant, count unchanged, no duplicate issue after release.
- Flush/reset: flush with 5 entries → count=0, o_uop_p=0 next cycle; i_rst=0 mid-issue → all outputs zero next edge.
